timing_leak_monitor: RTL and testbench
======================================

# timing_leak_monitor

Downstream observer for the constant-time multiplier two-copy test harness. Each trial starts both multiplier copies with the same `start` pulse. The block measures each copy's start-to-`productDone` latency in clock cycles and reports one result per trial, with a leak flag when the latencies differ. It also keeps sticky and cumulative leak statistics, so long randomized runs can be checked from a few registers instead of per-cycle waveform inspection.

## Interface
Parameters:
- `CNT_W`, 8: width of latency counters and latency outputs.
- `TIMEOUT`, 64: cycle count after which an unfinished trial is closed; must be ≤ 2^CNT_W − 1.
- `STAT_W`, 16: width of the trial and leak statistics counters.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  trial start; the same signal that drives both multiplier copies.
- `done_one`  in  1  `productDone` of copy one.
- `done_two`  in  1  `productDone` of copy two.
- `clear`  in  1  synchronous clear of the statistics.
- `busy`  out  1  high while a trial is being timed.
- `result_valid`  out  1  one-cycle pulse when a trial result is presented.
- `lat_one`  out  CNT_W  measured latency of copy one.
- `lat_two`  out  CNT_W  measured latency of copy two.
- `leak`  out  1  trial leaked; valid while `result_valid` is high.
- `timeout`  out  1  trial closed by timeout; valid while `result_valid` is high.
- `leak_sticky`  out  1  set by any leaking trial; held until `clear` or reset.
- `trial_count`  out  STAT_W  number of completed trials, saturating.
- `leak_count`  out  STAT_W  number of leaking trials, saturating.

## Operation
- FSM states:
  - IDLE: wait for a trial.
  - RUN: count cycles and capture each copy's latency.
  - REPORT: present the trial result for one cycle.
- IDLE → RUN: `start` sampled high.
  - `cnt` ← 0.
  - `got_one`, `got_two` ← 0.
- RUN, every edge:
  - `cnt` ← `cnt`+1.
  - If `done_one` && !`got_one`: `lat_one` ← `cnt`+1 and `got_one` ← 1. `done_two` is handled identically.
  - Later `done` pulses from an already-captured copy are ignored.
- RUN → REPORT: the edge on which both `got` flags are true, counting captures made on that same edge. Simultaneous dones produce equal latencies.
- RUN → REPORT on timeout: `cnt`+1 == `TIMEOUT` with a capture still missing.
  - Each missing latency ← all-ones.
  - `timeout` ← 1.
- REPORT:
  - `result_valid` = 1.
  - `leak` = (`lat_one` != `lat_two`) || `timeout`.
  - `trial_count` += 1.
  - `leak_count` += `leak`.
  - `leak_sticky` |= `leak`.
  - Next state IDLE, unconditionally.
- Input handling:
  - `start` is ignored in RUN and REPORT; there is no queuing.
  - `done_*` is ignored in IDLE and REPORT.
  - A `done_*` in the same cycle that `start` is sampled in IDLE is ignored, so the minimum measurable latency is 1.
- `lat_one` and `lat_two` hold their last values until the next trial overwrites them. Both are cleared on entering RUN.
- `clear`:
  - Zeroes `trial_count`, `leak_count` and `leak_sticky`.
  - Has priority over a coincident REPORT update; that trial is not counted.
  - Does not affect the FSM or the latency outputs.
- Both statistics counters saturate at all-ones.

## Timing
- Reset values (async, `rst` low): all outputs 0; state IDLE; `cnt` 0.
- Reset mid-trial aborts the trial with no result reported.
- `busy` = 1 in RUN only. It rises the cycle after `start` is sampled.
- Latency definition: `start` sampled at edge k, `done_x` first sampled high at edge k+n, gives `lat_x` = n.
- Result timing: `result_valid` is high for exactly the one cycle after the edge on which the last capture or timeout occurs.
- Updated statistics are visible the cycle after the `result_valid` cycle.
- Back-to-back trials: `start` is sampled in IDLE, at the earliest one cycle after `result_valid`. A trial therefore occupies n + 2 cycles minimum.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Equal latencies: `start`, then `done_one` and `done_two` both at n=5.
  - Expect: `result_valid` pulse with `lat_one`=`lat_two`=5, `leak`=0, `trial_count`=1, `leak_count`=0.
- Unequal latencies: `done_one` at n=4, `done_two` at n=7.
  - Expect: `lat_one`=4, `lat_two`=7, `leak`=1, `leak_sticky`=1, `leak_count`=1, with `result_valid` one cycle after the `done_two` edge.
- Timeout: `TIMEOUT`=16, only `done_one` at n=3.
  - Expect: at cnt+1=16, `timeout`=1, `leak`=1, `lat_one`=3, `lat_two`=8'hFF.
- Ignored inputs:
  - Repeated `done_one` pulses and a second `start` during RUN: no change to latencies or statistics.
  - `done_*` in the same cycle as `start`: not captured.
- Clear priority: `clear` asserted in the REPORT cycle of a leaking trial.
  - Expect: all statistics 0 afterwards.
- Reset mid-trial: drop `rst` at n=2.
  - Expect: all outputs 0 immediately, no `result_valid`.
  - A new trial after reset reports normally.

Source files
------------

// File: rtl/timing_leak_monitor_if.sv
// Signal bundle between the two-copy multiplier harness and the timing leak
// monitor. The harness drives the trial inputs; the monitor drives the results.
interface timing_leak_monitor_if #(
    parameter int CNT_W  = 8,
    parameter int STAT_W = 16
);
    logic              start;
    logic              done_one;
    logic              done_two;
    logic              clear;
    logic              busy;
    logic              result_valid;
    logic [CNT_W-1:0]  lat_one;
    logic [CNT_W-1:0]  lat_two;
    logic              leak;
    logic              timeout;
    logic              leak_sticky;
    logic [STAT_W-1:0] trial_count;
    logic [STAT_W-1:0] leak_count;

    modport master (
        output start, done_one, done_two, clear,
        input  busy, result_valid, lat_one, lat_two, leak, timeout,
               leak_sticky, trial_count, leak_count
    );

    modport slave (
        input  start, done_one, done_two, clear,
        output busy, result_valid, lat_one, lat_two, leak, timeout,
               leak_sticky, trial_count, leak_count
    );
endinterface

// File: rtl/timing_leak_monitor.sv
// Timing leak monitor: measures the start-to-done latency of two multiplier
// copies started together, reports one result per trial with a leak flag when
// the latencies differ (or a copy never finishes), and keeps saturating
// trial/leak statistics plus a sticky leak flag.
module timing_leak_monitor #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64,
    parameter int STAT_W  = 16
) (
    input logic                  clk,
    input logic                  rst,
    timing_leak_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        REPORT
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic              got_one, got_two;
    logic              cap_one, cap_two;
    logic              all_got, expired;
    logic              timed_out;
    logic [CNT_W-1:0]  lat_one_r, lat_two_r;
    logic              leak_now;
    logic [STAT_W-1:0] trial_r, leakc_r;
    logic              sticky_r;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic and capture conditions for the current RUN cycle.
    // NOTE: every signal gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        cnt_inc   = cnt + 1'b1;
        cap_one   = (state == RUN) && bus.done_one && !got_one;
        cap_two   = (state == RUN) && bus.done_two && !got_two;
        all_got   = (got_one || cap_one) && (got_two || cap_two);
        expired   = (cnt_inc == TIMEOUT_C);
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (all_got || expired) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Trial timing: cycle counter, first-done captures and timeout fill-in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            got_one   <= 1'b0;
            got_two   <= 1'b0;
            lat_one_r <= '0;
            lat_two_r <= '0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt       <= '0;
                        got_one   <= 1'b0;
                        got_two   <= 1'b0;
                        lat_one_r <= '0;
                        lat_two_r <= '0;
                        timed_out <= 1'b0;
                    end
                end
                RUN: begin
                    cnt <= cnt_inc;
                    if (cap_one) begin
                        lat_one_r <= cnt_inc;
                        got_one   <= 1'b1;
                    end
                    if (cap_two) begin
                        lat_two_r <= cnt_inc;
                        got_two   <= 1'b1;
                    end
                    // A copy still missing at the deadline reports all-ones.
                    if (expired && !all_got) begin
                        timed_out <= 1'b1;
                        if (!(got_one || cap_one)) lat_one_r <= '1;
                        if (!(got_two || cap_two)) lat_two_r <= '1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign leak_now = (lat_one_r != lat_two_r) || timed_out;

    // Saturating statistics, updated once per REPORT; clear wins over the update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trial_r  <= '0;
            leakc_r  <= '0;
            sticky_r <= 1'b0;
        end else if (bus.clear) begin
            trial_r  <= '0;
            leakc_r  <= '0;
            sticky_r <= 1'b0;
        end else if (state == REPORT) begin
            if (trial_r != '1)             trial_r <= trial_r + 1'b1;
            if (leak_now && leakc_r != '1) leakc_r <= leakc_r + 1'b1;
            if (leak_now)                  sticky_r <= 1'b1;
        end
    end

    // Outputs are decoded from registers only; leak/timeout read as 0 outside REPORT.
    assign bus.busy         = (state == RUN);
    assign bus.result_valid = (state == REPORT);
    assign bus.lat_one      = lat_one_r;
    assign bus.lat_two      = lat_two_r;
    assign bus.leak         = (state == REPORT) && leak_now;
    assign bus.timeout      = (state == REPORT) && timed_out;
    assign bus.leak_sticky  = sticky_r;
    assign bus.trial_count  = trial_r;
    assign bus.leak_count   = leakc_r;

endmodule

// File: tb/tb_timing_leak_monitor.sv
// Bench for timing_leak_monitor: a directed vector table, hand-written corner
// sequences (ignored inputs, reset mid-trial) and randomized trials checked
// against a trial-level reference model.
module tb_timing_leak_monitor;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;
    localparam int STAT_W  = 4;
    localparam int SAT     = (1 << STAT_W) - 1;
    localparam int ALL1    = (1 << CNT_W) - 1;

    typedef struct {
        int cyc;
        int l1;
        int l2;
        bit lk;
        bit to;
        int tc;
        int lc;
        bit st;
    } res_t;

    typedef struct {
        int   n1;
        int   n2;
        bit   clr;
        res_t e;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    int   m_tc = 0, m_lc = 0;
    bit   m_st = 0;

    timing_leak_monitor_if #(.CNT_W(CNT_W), .STAT_W(STAT_W)) bus ();

    timing_leak_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .STAT_W(STAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: latency is the first done cycle index within the deadline,
    // otherwise all-ones; the result lands at the later capture or the deadline.
    function automatic res_t predict(input int n1, input int n2);
        res_t r;
        bit c1 = (n1 >= 1) && (n1 <= TIMEOUT);
        bit c2 = (n2 >= 1) && (n2 <= TIMEOUT);
        r.l1  = c1 ? n1 : ALL1;
        r.l2  = c2 ? n2 : ALL1;
        r.to  = !(c1 && c2);
        r.cyc = r.to ? TIMEOUT : ((n1 > n2) ? n1 : n2);
        r.lk  = r.to || (r.l1 != r.l2);
        r.tc = 0; r.lc = 0; r.st = 0;
        return r;
    endfunction

    task automatic model_stats(input bit lk, input bit clr);
        if (clr) begin
            m_tc = 0; m_lc = 0; m_st = 0;
        end else begin
            if (m_tc < SAT) m_tc++;
            if (lk && m_lc < SAT) m_lc++;
            m_st = m_st | lk;
        end
    endtask

    task automatic compare(input string tag, input res_t g, input res_t e);
        check({tag, ".cycles"},  g.cyc, e.cyc);
        check({tag, ".lat_one"}, g.l1,  e.l1);
        check({tag, ".lat_two"}, g.l2,  e.l2);
        check({tag, ".leak"},    g.lk,  e.lk);
        check({tag, ".timeout"}, g.to,  e.to);
        check({tag, ".trials"},  g.tc,  e.tc);
        check({tag, ".leaks"},   g.lc,  e.lc);
        check({tag, ".sticky"},  g.st,  e.st);
    endtask

    // One trial from IDLE: start, done pulses at cycle n1/n2 (0 = never), then
    // the REPORT cycle (with optional clear) and the first cycle back in IDLE.
    // With noise set, done is also raised with start, repeated after capture,
    // and start is pulsed during RUN/REPORT.
    task automatic run_trial(input string tag, input int n1, input int n2,
                             input bit noise, input bit clr, output res_t o);
        o.cyc = 0;
        bus.start    = 1'b1;
        bus.clear    = 1'b0;
        bus.done_one = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.done_two = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        check({tag, ".busy_rise"}, bus.busy, 1'b1);
        for (int c = 1; c <= TIMEOUT + 4; c++) begin
            bus.start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.done_one = (c == n1) || (noise && n1 != 0 && c > n1 && $urandom_range(0, 1) == 1);
            bus.done_two = (c == n2) || (noise && n2 != 0 && c > n2 && $urandom_range(0, 1) == 1);
            @(posedge clk); #1;
            if (bus.result_valid) begin
                o.cyc = c;
                break;
            end
        end
        o.l1 = bus.lat_one;
        o.l2 = bus.lat_two;
        o.lk = bus.leak;
        o.to = bus.timeout;
        bus.clear    = clr;
        bus.start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.done_one = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.done_two = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        bus.clear = 1'b0; bus.start = 1'b0; bus.done_one = 1'b0; bus.done_two = 1'b0;
        check({tag, ".rv_single"}, bus.result_valid, 1'b0);
        check({tag, ".busy_idle"}, bus.busy, 1'b0);
        o.tc = bus.trial_count;
        o.lc = bus.leak_count;
        o.st = bus.leak_sticky;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},   bus.busy, 1'b0);
        check({tag, ".rv"},     bus.result_valid, 1'b0);
        check({tag, ".lat1"},   bus.lat_one, '0);
        check({tag, ".lat2"},   bus.lat_two, '0);
        check({tag, ".leak"},   bus.leak, 1'b0);
        check({tag, ".to"},     bus.timeout, 1'b0);
        check({tag, ".sticky"}, bus.leak_sticky, 1'b0);
        check({tag, ".trials"}, bus.trial_count, '0);
        check({tag, ".leaks"},  bus.leak_count, '0);
    endtask

    initial begin
        vec_t vecs[9];
        res_t o, e;
        bit   d1_seq[6], d2_seq[6], st_seq[6];
        int   n1, n2;
        bit   clr;

        // Directed vectors: {n1, n2, clear, {cycles, lat1, lat2, leak, timeout, trials, leaks, sticky}}.
        vecs[0] = '{5,  5,  0, '{5,  5,    5,    0, 0, 1, 0, 0}};
        vecs[1] = '{4,  7,  0, '{7,  4,    7,    1, 0, 2, 1, 1}};
        vecs[2] = '{3,  0,  0, '{16, 3,    ALL1, 1, 1, 3, 2, 1}};
        vecs[3] = '{2,  6,  1, '{6,  2,    6,    1, 0, 0, 0, 0}};
        vecs[4] = '{1,  1,  0, '{1,  1,    1,    0, 0, 1, 0, 0}};
        vecs[5] = '{0,  0,  0, '{16, ALL1, ALL1, 1, 1, 2, 1, 1}};
        vecs[6] = '{16, 16, 0, '{16, 16,   16,   0, 0, 3, 1, 1}};
        vecs[7] = '{9,  2,  0, '{9,  9,    2,    1, 0, 4, 2, 1}};
        vecs[8] = '{0,  16, 0, '{16, ALL1, 16,   1, 1, 5, 3, 1}};

        rst = 1'b0;
        bus.start = 1'b0; bus.done_one = 1'b0; bus.done_two = 1'b0; bus.clear = 1'b0;
        #12;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_trial($sformatf("vec%0d", i), vecs[i].n1, vecs[i].n2, 1'b0, vecs[i].clr, o);
            compare($sformatf("vec%0d", i), o, vecs[i].e);
            e = predict(vecs[i].n1, vecs[i].n2);
            model_stats(e.lk, vecs[i].clr);
        end

        // Ignored inputs: done with start, second start in RUN, repeated done_one.
        st_seq = '{1, 0, 0, 1, 0, 0};
        d1_seq = '{1, 0, 1, 1, 1, 0};
        d2_seq = '{1, 0, 0, 0, 0, 1};
        for (int c = 0; c < 6; c++) begin
            bus.start = st_seq[c]; bus.done_one = d1_seq[c]; bus.done_two = d2_seq[c];
            @(posedge clk); #1;
            if (c == 0) begin
                check("ign.lat1_cleared", bus.lat_one, '0);
                check("ign.lat2_cleared", bus.lat_two, '0);
            end
            if (c == 4) check("ign.rv_early", bus.result_valid, 1'b0);
        end
        check("ign.rv", bus.result_valid, 1'b1);
        check("ign.lat1", bus.lat_one, 8'd2);
        check("ign.lat2", bus.lat_two, 8'd5);
        check("ign.leak", bus.leak, 1'b1);
        bus.start = 1'b0; bus.done_one = 1'b0; bus.done_two = 1'b0;
        @(posedge clk); #1;
        model_stats(1'b1, 1'b0);
        check("ign.trials", bus.trial_count, m_tc);
        check("ign.leaks",  bus.leak_count, m_lc);

        // Reset mid-trial: abort at n=2, then a fresh trial reports normally.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.done_one = 1'b1;
        #2 rst = 1'b0;
        #1;
        check_all_zero("midrst");
        bus.done_one = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m_tc = 0; m_lc = 0; m_st = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("midrst.no_result", bus.result_valid, 1'b0);
        end
        run_trial("post_rst", 3, 3, 1'b0, 1'b0, o);
        e = predict(3, 3);
        model_stats(e.lk, 1'b0);
        e.tc = m_tc; e.lc = m_lc; e.st = m_st;
        compare("post_rst", o, e);

        // Randomized trials with noise; early ones never clear so counters saturate.
        for (int t = 0; t < 80; t++) begin
            n1  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
            n2  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
            clr = (t >= 20) && ($urandom_range(0, 15) == 0);
            run_trial($sformatf("rnd%0d", t), n1, n2, 1'b1, clr, o);
            e = predict(n1, n2);
            model_stats(e.lk, clr);
            e.tc = m_tc; e.lc = m_lc; e.st = m_st;
            compare($sformatf("rnd%0d", t), o, e);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
